// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_unit
//  Description : Instruction-fetch front end. Walks a word-aligned PC, queues
//                {pc, instr} pairs in a small FIFO for decode, and flushes on
//                branch redirects. Optional halt-on-"B ." via IFETCH_HALT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
`ifdef IFETCH_HALT_EN
    output logic        halted,
`endif
    input  logic        br_taken,
    input  logic [31:0] br_target
);

    localparam int               PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W       = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [0:0]       c_ST_FETCH  = 1'b0;

    logic [31:0]      r_pc;
    logic [31:0]      r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;
    logic [0:0]       w_state;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef IFETCH_HALT_EN
    localparam logic [0:0]  c_ST_HALTED = 1'b1;
    localparam logic [31:0] c_HALT_WORD = 32'hEAFF_FFFE;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= c_ST_FETCH;
        else          r_state <= w_state_nxt;
    end

    // The halting word itself is still enqueued; only later pushes stop.
    always_comb begin
        w_state_nxt = r_state;
        if (br_taken)
            w_state_nxt = c_ST_FETCH;
        else if (w_push && (imem_rd == c_HALT_WORD))
            w_state_nxt = c_ST_HALTED;
    end

    assign w_state = r_state;
    assign halted  = (r_state == c_ST_HALTED);
`else
    assign w_state = c_ST_FETCH;
`endif

    assign imem_a      = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? r_mem_pc[r_rd_ptr]    : 32'h0;
    assign w_pop       = instr_valid & instr_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push      = (w_state == c_ST_FETCH) & ~br_taken
                       & ((r_count < c_DEPTH_CNT) | w_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc     <= RESET_PC & ~32'h3;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (br_taken) begin
            r_pc     <= br_target & ~32'h3;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_pc;
            r_mem_instr[r_wr_ptr] <= imem_rd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Self-checking bench for ifetch_unit (table vectors, halt
//                sequence, randomized run against a queue-based model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam int          DEPTH     = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hEAFF_FFFE;

    logic        clk;
    logic        reset_n;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [31:0] br_target;
`ifdef IFETCH_HALT_EN
    logic        halted;
`endif

    bit special_en;
    int n_checks;
    int n_fail;

    ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
`ifdef IFETCH_HALT_EN
        .halted      (halted),
`endif
        .br_taken    (br_taken),
        .br_target   (br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: address ^ A5A5_0000, with an optional "B ." at xx08.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (special_en && (a[7:0] == 8'h08)) return HALT_WORD;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rd = (special_en && (imem_a[7:0] == 8'h08)) ? HALT_WORD
                                                            : (imem_a ^ 32'hA5A5_0000);

    // Reference model: a queue of fetched entries and a program counter.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_halt;

    function automatic void model_step();
        bit          pop;
        bit          push;
        logic [31:0] w;
        pop = (q.size() > 0) && instr_ready;
        if (!reset_n) begin
            q.delete();
            m_pc   = RESET_PC & ~32'h3;
            m_halt = 0;
        end else if (br_taken) begin
            q.delete();
            m_pc   = br_target & ~32'h3;
            m_halt = 0;
        end else begin
            push = !m_halt && ((q.size() < DEPTH) || pop);
            if (pop) void'(q.pop_front());
            if (push) begin
                w = mem_word(m_pc);
                q.push_back('{pc: m_pc, ins: w});
`ifdef IFETCH_HALT_EN
                if (w == HALT_WORD) m_halt = 1;
`endif
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("model imem_a", imem_a, m_pc);
        chk("model instr_valid", {31'b0, instr_valid}, {31'b0, q.size() > 0});
        chk("model instr", instr, (q.size() > 0) ? q[0].ins : 32'h0);
        chk("model instr_pc", instr_pc, (q.size() > 0) ? q[0].pc : 32'h0);
`ifdef IFETCH_HALT_EN
        chk("model halted", {31'b0, halted}, {31'b0, m_halt});
`endif
    endtask

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_a;
        logic        e_v;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        special_en  = 0;
        reset_n     = 1'b0;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'h0;
        m_pc        = 32'h0;
        m_halt      = 0;

        // Streaming from reset
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'h0,  1'b0, 32'h0,        32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'h4,  1'b1, 32'hA5A5_0000, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'h8,  1'b1, 32'hA5A5_0004, 32'h4});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'hC,  1'b1, 32'hA5A5_0008, 32'h8});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'h10, 1'b1, 32'hA5A5_000C, 32'hC});
        // Backpressure: fill, stall, then pop and push together
        tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 32'h0,        32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 32'h4,  1'b1, 32'hA5A5_0000, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 32'h8,  1'b1, 32'hA5A5_0000, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 32'h8,  1'b1, 32'hA5A5_0000, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'hC,  1'b1, 32'hA5A5_0004, 32'h4});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 32'hC,  1'b1, 32'hA5A5_0004, 32'h4});
        // Redirect from a full FIFO, unaligned target
        tbl.push_back('{1'b1, 1'b0, 1'b1, 32'h103, 32'h100, 1'b0, 32'h0,        32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   32'h104, 1'b1, 32'hA5A5_0100, 32'h100});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,   32'h108, 1'b1, 32'hA5A5_0104, 32'h104});
        // PC wrap at the top of the address space
        tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h5A5A_FFFC, 32'hFFFF_FFFC});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'h4, 1'b1, 32'hA5A5_0000, 32'h0});
        // Reset beats a simultaneous branch
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0,        32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,  32'h4, 1'b1, 32'hA5A5_0000, 32'h0});

        @(negedge clk);
        foreach (tbl[i]) begin
            reset_n     = tbl[i].rst_n;
            instr_ready = tbl[i].rdy;
            br_taken    = tbl[i].br;
            br_target   = tbl[i].tgt;
            step();
            chk($sformatf("vec%0d imem_a", i), imem_a, tbl[i].e_a);
            chk($sformatf("vec%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_v});
            chk($sformatf("vec%0d instr", i), instr, tbl[i].e_ins);
            chk($sformatf("vec%0d instr_pc", i), instr_pc, tbl[i].e_pc);
        end

        // "B ." at address 8
        special_en  = 1;
        reset_n     = 1'b0;
        br_taken    = 1'b0;
        instr_ready = 1'b1;
        step();
        reset_n = 1'b1;
        repeat (3) step();
`ifdef IFETCH_HALT_EN
        chk("halt set", {31'b0, halted}, 32'h1);
        chk("halt pc held", imem_a, 32'hC);
`else
        chk("no-halt pc advances", imem_a, 32'hC);
`endif
        repeat (3) step();
`ifdef IFETCH_HALT_EN
        chk("halt drained", {31'b0, instr_valid}, 32'h0);
        chk("halt pc still held", imem_a, 32'hC);
`else
        chk("no-halt keeps fetching", imem_a, 32'h18);
`endif
        br_taken  = 1'b1;
        br_target = 32'h20;
        step();
        br_taken = 1'b0;
`ifdef IFETCH_HALT_EN
        chk("halt cleared", {31'b0, halted}, 32'h0);
`endif
        chk("resume addr", imem_a, 32'h20);
        step();
        chk("resume next", imem_a, 32'h24);
        chk("resume head pc", instr_pc, 32'h20);

        // Randomized run
        for (int n = 0; n < 400; n++) begin
            reset_n     = ($urandom_range(0, 39) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            br_taken    = ($urandom_range(0, 9) == 0);
            br_target   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
